// File: rtl/mem_responder.sv
// Memory-side responder for the datapath: arbitrates data and fetch requests onto a
// single-port RAM, waits for completion (or times out) and returns one-cycle hit pulses.
module mem_responder #(
    parameter int                WORD_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [WORD_W-1:0] ERR_WORD = WORD_W'(32'hBAD1BAD1)
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    input  logic              halt,
    output logic              ihit,
    output logic              dhit,
    output logic [WORD_W-1:0] iload,
    output logic [WORD_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              busy,
    output logic              mem_err
);

    localparam int         CNT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [1:0] RS_ACCESS = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DACC,
        S_IACC,
        S_DHIT,
        S_IHIT
    } state_t;

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   store_q, store_d;
    logic                wr_q, wr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   dload_q, dload_d;
    logic [WORD_W-1:0]   iload_q, iload_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_inc;
    logic                timed_out;

    // cnt_inc is the number of access cycles elapsed including the current one,
    // so the access is forced to complete on its TIMEOUT-th cycle.
    assign cnt_inc   = cnt_q + 1'b1;
    assign timed_out = (cnt_inc == CNT_W'(TIMEOUT));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            store_q <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            dload_q <= '0;
            iload_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            dload_q <= dload_d;
            iload_q <= iload_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        store_d  = store_q;
        wr_d     = wr_q;
        cnt_d    = cnt_q;
        dload_d  = dload_q;
        iload_d  = iload_q;
        err_d    = err_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;

        case (state_q)
            S_IDLE: begin
                // Data wins over fetch; a simultaneous load+store is a store.
                if (dREN || dWEN) begin
                    state_d = S_DACC;
                    addr_d  = daddr;
                    store_d = dstore;
                    wr_d    = dWEN;
                    cnt_d   = '0;
                end else if (iREN && !halt) begin
                    state_d = S_IACC;
                    addr_d  = iaddr;
                    cnt_d   = '0;
                end
            end
            S_DACC: begin
                ramaddr  = addr_q;
                ramWEN   = wr_q;
                ramREN   = !wr_q;
                ramstore = store_q;
                cnt_d    = cnt_inc;
                if (ramstate == RS_ACCESS) begin
                    if (!wr_q) dload_d = ramload;
                    state_d = S_DHIT;
                end else if (timed_out) begin
                    if (!wr_q) dload_d = ERR_WORD;
                    err_d   = 1'b1;
                    state_d = S_DHIT;
                end
            end
            S_IACC: begin
                ramaddr = addr_q;
                ramREN  = 1'b1;
                cnt_d   = cnt_inc;
                if (ramstate == RS_ACCESS) begin
                    iload_d = ramload;
                    state_d = S_IHIT;
                end else if (timed_out) begin
                    iload_d = ERR_WORD;
                    err_d   = 1'b1;
                    state_d = S_IHIT;
                end
            end
            S_DHIT:  state_d = S_IDLE;
            S_IHIT:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign dhit    = (state_q == S_DHIT);
    assign ihit    = (state_q == S_IHIT);
    assign dload   = dload_q;
    assign iload   = iload_q;
    assign busy    = (state_q != S_IDLE);
    assign mem_err = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand sequences and random transactions
// checked against a transaction-level prediction of winner, access length and hit data.
module tb_mem_responder;

    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hBAD1BAD1;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN, halt;
    logic [31:0] iaddr, daddr, dstore;
    logic        ihit, dhit;
    logic [31:0] iload, dload;
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;
    logic        busy, mem_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_dload = '0;
    logic [31:0] exp_iload = '0;
    logic        exp_err   = 1'b0;

    always #5 CLK = ~CLK;

    mem_responder #(.WORD_W(32), .TIMEOUT(TO), .ERR_WORD(ERR)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .halt(halt),
        .ihit(ihit), .dhit(dhit), .iload(iload), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .busy(busy), .mem_err(mem_err)
    );

    typedef struct {
        logic        iren, dren, dwen, halt;
        logic [31:0] iaddr, daddr, dstore, rdata;
        int          lat;       // non-ACCESS cycles the RAM inserts before ACCESS
        int          exp_kind;  // 0 none, 1 data, 2 fetch
        logic        exp_wr;
        logic [31:0] exp_addr;
    } vec_t;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic ir, input logic dr, input logic dw, input logic h,
                                input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] ds, input int lat, input logic [31:0] rd,
                                input int kind, input logic wr, input logic [31:0] ea);
        vec_t v;
        v.iren = ir; v.dren = dr; v.dwen = dw; v.halt = h;
        v.iaddr = ia; v.daddr = da; v.dstore = ds; v.lat = lat; v.rdata = rd;
        v.exp_kind = kind; v.exp_wr = wr; v.exp_addr = ea;
        return v;
    endfunction

    function automatic int predict(input vec_t v);
        if (v.dren || v.dwen) return 1;
        if (v.iren && !v.halt) return 2;
        return 0;
    endfunction

    task automatic clear_req();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0; halt = 1'b0;
    endtask

    // Entry: at a negedge with the DUT idle and the request already driven.
    // Exit: at the negedge of the hit cycle.
    task automatic run_access(input bit is_d, input bit wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input int lat,
                              input logic [31:0] rdata, input bit disturb, input string tag);
        int n;
        bit to_;
        n   = (lat + 1 < TO) ? lat + 1 : TO;
        to_ = (lat + 1 > TO);
        for (int k = 0; k < n; k++) begin
            @(negedge CLK);
            check1({tag, " ramREN"}, ramREN, is_d ? !wr : 1'b1);
            check1({tag, " ramWEN"}, ramWEN, is_d & wr);
            check32({tag, " ramaddr"}, ramaddr, addr);
            if (is_d) check32({tag, " ramstore"}, ramstore, wdata);
            check1({tag, " busy"}, busy, 1'b1);
            check1({tag, " early hit"}, dhit | ihit, 1'b0);
            if (k == 0 && disturb) begin
                daddr = $urandom; dstore = $urandom; iaddr = $urandom;
                dREN = 1'($urandom_range(0, 1)); dWEN = 1'($urandom_range(0, 1));
                iREN = 1'($urandom_range(0, 1)); halt = 1'($urandom_range(0, 1));
            end
            if (k == lat) begin
                ramstate = 2'd2;
                ramload  = rdata;
            end else begin
                case ($urandom_range(0, 3))
                    0:       ramstate = 2'd0;
                    3:       ramstate = 2'd3;
                    default: ramstate = 2'd1;
                endcase
                ramload = $urandom;
            end
        end
        @(negedge CLK);
        ramstate = 2'd0;
        ramload  = $urandom;
        if (to_) exp_err = 1'b1;
        if (is_d && !wr) exp_dload = to_ ? ERR : rdata;
        if (!is_d) exp_iload = to_ ? ERR : rdata;
        check1({tag, " dhit"}, dhit, is_d);
        check1({tag, " ihit"}, ihit, !is_d);
        check32({tag, " dload"}, dload, exp_dload);
        check32({tag, " iload"}, iload, exp_iload);
        check1({tag, " mem_err"}, mem_err, exp_err);
        check1({tag, " strobes in hit"}, ramREN | ramWEN, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input bit disturb, input string tag);
        iREN = v.iren; dREN = v.dren; dWEN = v.dwen; halt = v.halt;
        iaddr = v.iaddr; daddr = v.daddr; dstore = v.dstore;
        ramstate = 2'd0;
        if (v.exp_kind == 0) begin
            repeat (3) begin
                @(negedge CLK);
                check1({tag, " idle busy"}, busy, 1'b0);
                check1({tag, " idle strobes"}, ramREN | ramWEN, 1'b0);
                check1({tag, " idle hit"}, ihit | dhit, 1'b0);
            end
            clear_req();
        end else begin
            run_access(v.exp_kind == 1, v.exp_wr, v.exp_addr, v.dstore, v.lat, v.rdata,
                       disturb, tag);
            clear_req();
            @(negedge CLK);
            check1({tag, " single-cycle hit"}, ihit | dhit, 1'b0);
            check1({tag, " back to idle"}, busy, 1'b0);
        end
    endtask

    vec_t tbl[11];

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0;
        clear_req();
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = 2'd0;

        tbl[0]  = mk(0, 1, 0, 0, 32'h0,   32'h100, 32'h0,        2, 32'hDEADBEEF, 1, 0, 32'h100);
        tbl[1]  = mk(0, 0, 1, 0, 32'h0,   32'h200, 32'h12345678, 0, 32'h0,        1, 1, 32'h200);
        tbl[2]  = mk(1, 0, 0, 0, 32'h4,   32'h0,   32'h0,        1, 32'h8C010000, 2, 0, 32'h4);
        tbl[3]  = mk(0, 1, 1, 0, 32'h0,   32'h44,  32'hAAAA5555, 0, 32'h11111111, 1, 1, 32'h44);
        tbl[4]  = mk(1, 0, 0, 1, 32'h8,   32'h0,   32'h0,        0, 32'h0,        0, 0, 32'h0);
        tbl[5]  = mk(0, 0, 0, 0, 32'h8,   32'h0,   32'h0,        0, 32'h0,        0, 0, 32'h0);
        tbl[6]  = mk(1, 1, 0, 1, 32'hC,   32'h48,  32'h0,        3, 32'h0BADF00D, 1, 0, 32'h48);
        tbl[7]  = mk(0, 1, 0, 0, 32'h0,   32'h4C,  32'h0,        9, 32'h22222222, 1, 0, 32'h4C);
        tbl[8]  = mk(1, 0, 0, 0, 32'h10,  32'h0,   32'h0,        0, 32'h33333333, 2, 0, 32'h10);
        tbl[9]  = mk(1, 0, 0, 0, 32'h14,  32'h0,   32'h0,        7, 32'h44444444, 2, 0, 32'h14);
        tbl[10] = mk(0, 0, 1, 0, 32'h0,   32'h50,  32'h55555555, 5, 32'h0,        1, 1, 32'h50);

        repeat (2) @(negedge CLK);
        check1("reset busy", busy, 1'b0);
        check1("reset strobes", ramREN | ramWEN, 1'b0);
        check1("reset hits", ihit | dhit, 1'b0);
        check32("reset dload", dload, 32'h0);
        check32("reset iload", iload, 32'h0);
        check32("reset ramaddr", ramaddr, 32'h0);
        check32("reset ramstore", ramstore, 32'h0);
        check1("reset mem_err", mem_err, 1'b0);
        nRST = 1'b1;

        // Reset in the middle of a data access
        @(negedge CLK);
        dREN = 1'b1; daddr = 32'h40; ramstate = 2'd1;
        @(negedge CLK);
        check1("midrst ramREN before", ramREN, 1'b1);
        #2 nRST = 1'b0;
        #1;
        check1("midrst ramREN drops", ramREN, 1'b0);
        check1("midrst busy", busy, 1'b0);
        check1("midrst mem_err", mem_err, 1'b0);
        clear_req();
        ramstate = 2'd0;
        @(negedge CLK);
        nRST = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check1("midrst no hit", dhit | ihit, 1'b0);
        end

        for (int i = 0; i < 11; i++) run_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // Simultaneous fetch and load: data first, held fetch follows
        iREN = 1'b1; iaddr = 32'h0; dREN = 1'b1; daddr = 32'h80; dstore = 32'h0;
        run_access(1'b1, 1'b0, 32'h80, 32'h0, 1, 32'h66666666, 1'b0, "simul data");
        dREN = 1'b0;
        @(negedge CLK);
        check1("simul gap hit", ihit | dhit, 1'b0);
        run_access(1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h77777777, 1'b0, "simul fetch");
        clear_req();
        @(negedge CLK);
        check1("simul idle", busy, 1'b0);

        // Halt blocks fetches but not stores
        halt = 1'b1; iREN = 1'b1; iaddr = 32'h500;
        repeat (20) begin
            @(negedge CLK);
            check1("halt fetch blocked", busy | ramREN | ihit, 1'b0);
        end
        dWEN = 1'b1; daddr = 32'h600; dstore = 32'hCAFE0001;
        run_access(1'b1, 1'b1, 32'h600, 32'hCAFE0001, 1, 32'h0, 1'b0, "halt store");
        dWEN = 1'b0; halt = 1'b1; iREN = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            check1("halt after store", busy | ramREN | ihit | dhit, 1'b0);
        end
        clear_req();

        // Fetch already in progress completes although halt rises
        iREN = 1'b1; iaddr = 32'h700;
        @(negedge CLK);
        check1("halt midfetch ramREN", ramREN, 1'b1);
        halt = 1'b1;
        ramstate = 2'd2; ramload = 32'h88888888;
        @(negedge CLK);
        ramstate = 2'd0;
        exp_iload = 32'h88888888;
        check1("halt midfetch ihit", ihit, 1'b1);
        check32("halt midfetch iload", iload, exp_iload);
        clear_req();
        @(negedge CLK);
        check1("halt midfetch idle", busy, 1'b0);

        // Random transactions against the transaction-level prediction
        for (int t = 0; t < 150; t++) begin
            vec_t v;
            v.iren   = 1'($urandom_range(0, 1));
            v.dren   = ($urandom_range(0, 9) < 3);
            v.dwen   = ($urandom_range(0, 9) < 3);
            v.halt   = ($urandom_range(0, 3) == 0);
            v.iaddr  = $urandom;
            v.daddr  = $urandom;
            v.dstore = $urandom;
            v.rdata  = $urandom;
            v.lat    = $urandom_range(0, 6);
            v.exp_kind = predict(v);
            v.exp_wr   = v.dwen;
            v.exp_addr = (v.exp_kind == 1) ? v.daddr : v.iaddr;
            run_vec(v, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Sequential responder for the datapath's memory requests: the instruction-fetch read and the control unit's data load/store strobes (dREN/dWEN with dmemaddr/dmemstore).
- Arbitrates the two request sources onto a single-port RAM, waits for RAM completion, and returns one-cycle ihit/dhit pulses with registered load data.
- Sits between the datapath and the RAM model; it is the memory end of the control unit's data-request interface.

Parameters:
- WORD_W, 32, data/address width.
- TIMEOUT, 255, maximum cycles waiting in an access state before forced completion.
- ERR_WORD, 32'hBAD1BAD1, load data returned on timeout.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction fetch request.
- iaddr  in  WORD_W  fetch address.
- dREN  in  1  data load request.
- dWEN  in  1  data store request.
- daddr  in  WORD_W  data address.
- dstore  in  WORD_W  store data.
- halt  in  1  CPU halted; blocks new fetches.
- ihit  out  1  one-cycle fetch completion pulse.
- dhit  out  1  one-cycle data completion pulse.
- iload  out  WORD_W  fetched instruction, valid when ihit=1.
- dload  out  WORD_W  loaded data, valid when dhit=1 for a load.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  WORD_W  RAM address.
- ramstore  out  WORD_W  RAM write data.
- ramload  in  WORD_W  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS (done this cycle), 3 ERROR.
- busy  out  1  high in any state other than IDLE.
- mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (async, nRST=0): state=IDLE; all outputs 0; timeout counter 0; mem_err 0. RAM strobes drop immediately, including mid-access. Any in-flight request is abandoned with no hit.
- States: IDLE, DACC, IACC, DHIT, IHIT.
- IDLE arbitration:
  - dREN|dWEN -> DACC; latch daddr, dstore, op = write if dWEN else read.
  - Otherwise iREN & !halt -> IACC; latch iaddr.
  - Otherwise stay in IDLE.
  - Data always has priority over fetch. dREN=dWEN=1 is treated as a write.
- DACC/IACC:
  - Drive ramaddr from the latched address. DACC drives ramWEN=op_write, ramREN=!op_write, ramstore=latched store data. IACC drives ramREN=1.
  - Requester inputs are ignored during access; a withdrawn request still completes.
- Completion:
  - ramstate==ACCESS -> register ramload into dload (read only) or iload; go to DHIT or IHIT.
  - ramstate==ERROR or BUSY/FREE -> hold and retry.
- Timeout: counter increments every cycle in an access state and clears on entry. When counter==TIMEOUT without ACCESS:
  - force completion with load data = ERR_WORD;
  - set mem_err (sticky until reset);
  - proceed to the HIT state.
- DHIT/IHIT: assert dhit or ihit for exactly 1 cycle; RAM strobes low; next state IDLE.
- Latency: request seen in IDLE at cycle N, ACCESS at cycle N+k -> hit at N+k+1. Minimum 3 cycles from request to hit (IDLE, ACC, HIT).
- dload/iload hold their values until overwritten by the next completion of the same kind.
- After a hit, a request still held in IDLE is treated as a new access. Requesters must drop the strobe on hit.
- halt=1: fetches are never started, but pending and new data requests are still serviced. An IACC already in progress completes normally.
- busy = (state != IDLE).

Test Plan:
- Reset mid-access: assert dREN daddr=0x40; in DACC, pulse nRST low -> ramREN drops same cycle, no dhit, state IDLE, mem_err=0.
- Simple load: dREN=1 daddr=0x100; RAM returns ACCESS after 2 BUSY cycles with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x100 for 3 cycles; dhit=1 for 1 cycle next; dload=0xDEADBEEF.
- Store: dWEN=1 daddr=0x200 dstore=0x12345678, ACCESS immediate -> ramWEN=1, ramstore=0x12345678 for 1 cycle; dhit pulse; dload unchanged.
- Simultaneous requests: iREN=1 iaddr=0x0 and dREN=1 daddr=0x80 same cycle -> data access first (ramaddr=0x80); after dhit and dREN drop, fetch of 0x0; ihit follows.
- Halt gating: halt=1, iREN=1 for 20 cycles -> ramREN stays 0, no ihit. Then dWEN=1 while halted -> store serviced, dhit pulses.
- Timeout: TIMEOUT=4; dREN=1, ramstate stuck BUSY -> after 4 access cycles dhit pulses with dload=0xBAD1BAD1 and mem_err=1 (stays 1). Next normal access leaves mem_err=1.
